// File: rtl/score_display_scan.sv
// score_display_scan: 3-digit multiplexed common-anode 7-seg driver.
// Optional: LEADING_ZERO_BLANK_EN darkens leading-zero tens/hundreds.
module score_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] an
);

  typedef enum logic [1:0] {
    ONES  = 2'd0,
    TENS  = 2'd1,
    HUNDS = 2'd2
  } idx_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [2:0]       AN_OFF   = 3'b111;

  logic [CNT_W-1:0] r_cnt;
  idx_t             r_idx;
  logic [3:0]       r_snap1;
  logic [3:0]       r_snap2;
  logic [3:0]       r_snap3;
  logic             r_run;
  logic             r_blank;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;

  logic       w_tick;
  logic       w_slot0;
  logic       w_dark;
  logic       w_lz;
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  idx_t       w_idx_nxt;

  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_slot0 = (r_cnt == '0);

  // Select the snapshot digit for the active slot and the next index.
  always_comb begin
    w_digit   = r_snap1;
    w_idx_nxt = ONES;
    unique case (r_idx)
      ONES: begin
        w_digit   = r_snap1;
        w_idx_nxt = TENS;
      end
      TENS: begin
        w_digit   = r_snap2;
        w_idx_nxt = HUNDS;
      end
      HUNDS: begin
        w_digit   = r_snap3;
        w_idx_nxt = ONES;
      end
      default: begin
        w_digit   = r_snap1;
        w_idx_nxt = ONES;
      end
    endcase
  end

  // BCD to active-low segments; non-decimal codes show a dash.
  always_comb begin
    w_dec = 7'h3F;
    case (w_digit)
      4'd0:    w_dec = 7'h40;
      4'd1:    w_dec = 7'h79;
      4'd2:    w_dec = 7'h24;
      4'd3:    w_dec = 7'h30;
      4'd4:    w_dec = 7'h19;
      4'd5:    w_dec = 7'h12;
      4'd6:    w_dec = 7'h02;
      4'd7:    w_dec = 7'h78;
      4'd8:    w_dec = 7'h00;
      4'd9:    w_dec = 7'h10;
      default: w_dec = 7'h3F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading zeros of the captured frame stay dark; ones never does.
  always_comb begin
    w_lz = 1'b0;
    if (r_idx == HUNDS)
      w_lz = (r_snap3 == 4'd0);
    else if (r_idx == TENS)
      w_lz = (r_snap3 == 4'd0) && (r_snap2 == 4'd0);
  end
`else
  assign w_lz = 1'b0;
`endif

  // blank is latched on the GAP->DRIVE edge and held for the slot.
  assign w_dark = !r_run || w_lz || (w_slot0 ? blank : r_blank);

  // Prescaler, digit scan, frame snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= HUNDS;
      r_snap1 <= 4'd0;
      r_snap2 <= 4'd0;
      r_snap3 <= 4'd0;
      r_run   <= 1'b0;
      r_blank <= 1'b0;
      r_seg   <= SEG_OFF;
      r_an    <= AN_OFF;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_idx_nxt;
      r_run <= 1'b1;
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
      if (r_idx == HUNDS) begin
        r_snap1 <= num1;
        r_snap2 <= num2;
        r_snap3 <= num3;
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_slot0)
        r_blank <= blank;
      if (w_dark) begin
        r_seg <= SEG_OFF;
        r_an  <= AN_OFF;
      end else begin
        r_seg <= w_dec;
        r_an  <= ~(3'b001 << r_idx);
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: directed checks of scan, snapshot, blank,
// decode, leading-zero option and asynchronous reset.
module tb_score_display_scan;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic       blank;
  logic [6:0] seg;
  logic [2:0] an;

  int errors;
  int checks;

  score_display_scan #(
    .SCAN_DIV(SD),
    .CNT_W   (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .num1 (num1),
    .num2 (num2),
    .num3 (num3),
    .blank(blank),
    .seg  (seg),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected {an,seg} sampled after the k-th rising edge past reset
  // release, with no blanking of any kind.
  function automatic logic [9:0] exp_at(input int k,
      input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
    int p;
    int s;
    logic [3:0] d;
    if (k < SD) return {3'b111, 7'h7F};
    p = (k - SD) % SD;
    s = ((k - SD) / SD) % 3;
    if (p == 0) return {3'b111, 7'h7F};
    d = (s == 0) ? d1 : (s == 1) ? d2 : d3;
    case (s)
      0: return {3'b110, dec(d)};
      1: return {3'b101, dec(d)};
      default: return {3'b011, dec(d)};
    endcase
  endfunction

  task automatic apply_reset(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c);
    @(negedge clk);
    rst   = 1'b1;
    blank = 1'b0;
    num1  = a;
    num2  = b;
    num3  = c;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    num1 = 4'd9; num2 = 4'd8; num3 = 4'd7; blank = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg} !== {3'b111, 7'h7F}) begin
        errors++;
        $display("FAIL reset cyc%0d an=%b seg=%h want an=111 seg=7f",
                 i, an, seg);
      end
    end
  endtask

  task automatic test_first_frame();
    logic [9:0] e;
    apply_reset(4'd3, 4'd2, 4'd1);
    checks++;
    if ({an, seg} !== {3'b111, 7'h7F}) begin
      errors++;
      $display("FAIL first_frame k0 an=%b seg=%h want 111/7f", an, seg);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = exp_at(k, 4'd3, 4'd2, 4'd1);
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL first_frame k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
    end
  endtask

  task automatic test_decode();
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    for (int d = 0; d < 16; d++) begin
      apply_reset(4'(d), 4'd2, 4'd1);
      for (int k = 1; k <= SD + 1; k++) @(negedge clk);
      checks++;
      if (an !== 3'b110 || seg !== tbl[d]) begin
        errors++;
        $display("FAIL decode d=%0d an=%b seg=%h want 110/%h",
                 d, an, seg, tbl[d]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [9:0] e;
    apply_reset(4'd3, 4'd2, 4'd1);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k <= 4 * SD)
        e = exp_at(k, 4'd3, 4'd2, 4'd1);
      else
        e = exp_at(k, 4'd7, 4'd2, 4'd6);
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL snapshot k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
      if (k == 9) begin
        num1 = 4'd7;
        num3 = 4'd6;
      end
    end
  endtask

  task automatic test_invalid_bcd();
    apply_reset(4'd3, 4'hC, 4'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k >= 9) begin
        checks++;
        if (an !== 3'b101 || seg !== 7'h3F) begin
          errors++;
          $display("FAIL invalid_bcd k%0d an=%b seg=%h want 101/3f",
                   k, an, seg);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [9:0] e;
    apply_reset(4'd3, 4'd2, 4'd1);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 15)
        e = {3'b111, 7'h7F};
      else
        e = exp_at(k, 4'd3, 4'd2, 4'd1);
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL blank k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
      if (k == 4) blank = 1'b1;
      if (k == 13) blank = 1'b0;
    end
  endtask

  task automatic test_leading_zero();
    logic [9:0] e;
    apply_reset(4'd5, 4'd0, 4'd0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      e = exp_at(k, 4'd5, 4'd0, 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      if (e[9:7] != 3'b110) e = {3'b111, 7'h7F};
`endif
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL lz_500 k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
    end
    apply_reset(4'd5, 4'd0, 4'd1);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      e = exp_at(k, 4'd5, 4'd0, 4'd1);
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL lz_501 k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] e;
    apply_reset(4'd3, 4'd2, 4'd1);
    for (int k = 1; k <= 9; k++) @(negedge clk);
    checks++;
    if (an !== 3'b101 || seg !== 7'h24) begin
      errors++;
      $display("FAIL mid_reset_pre an=%b seg=%h want 101/24", an, seg);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({an, seg} !== {3'b111, 7'h7F}) begin
      errors++;
      $display("FAIL mid_reset_async an=%b seg=%h want 111/7f", an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = exp_at(k, 4'd3, 4'd2, 4'd1);
      checks++;
      if ({an, seg} !== e) begin
        errors++;
        $display("FAIL mid_reset k%0d an=%b seg=%h want an=%b seg=%h",
                 k, an, seg, e[9:7], e[6:0]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    blank  = 1'b0;
    num1   = 4'd0;
    num2   = 4'd0;
    num3   = 4'd0;
    test_reset();
    test_first_frame();
    test_decode();
    test_snapshot();
    test_invalid_bcd();
    test_blank();
    test_leading_zero();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
